// File: rtl/cyclic_pkg.sv
// Shared constants and state type for the (7,4) cyclic encoder, g(x)=x^3+x+1.
package cyclic_pkg;

    localparam int N_LEN = 7;
    localparam int K_LEN = 4;
    localparam int R_LEN = 3;
    localparam logic [3:0] GEN_POLY = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/cyclic_lfsr3.sv
// Three-stage parity LFSR for g(x)=x^3+x+1; zero-feedback shift drains parity.
module cyclic_lfsr3
    import cyclic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic             feedback_en,
    input  logic             din,
    output logic [R_LEN-1:0] r
);

    logic f;

    assign f = din ^ r[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (ena) begin
            if (clr) begin
                r <= '0;
            end else if (feedback_en) begin
                r <= {r[1], r[0] ^ f, f};
            end else begin
                r <= {r[1], r[0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/cyclic_encoder.sv
// Serial systematic (7,4) cyclic encoder; CYCLIC_ENC_PARALLEL_OUT_EN adds cw_out/cw_valid.
module cyclic_encoder
    import cyclic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [K_LEN-1:0] msg,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             cw_last
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
    ,
    output logic [N_LEN-1:0] cw_out,
    output logic             cw_valid
`endif
);

    state_t           state, state_d;
    logic [1:0]       cnt, cnt_d;
    logic [K_LEN-1:0] msg_q, msg_d;
    logic             sout_d, valid_d, last_d;
    logic             accept;
    logic [R_LEN-1:0] r;

    assign in_ready = ena && ((state == IDLE) ||
                              (state == PAR && cnt == 2'(R_LEN - 1)));
    assign accept   = in_valid && in_ready;

    cyclic_lfsr3 u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .clr         (accept),
        .feedback_en (state == MSG),
        .din         (msg_q[K_LEN-1]),
        .r           (r)
    );

    // sout is registered, so each edge loads the bit shown next cycle.
    // The next r2 equals the current r1 in both shift modes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        msg_d   = msg_q;
        sout_d  = sout;
        valid_d = sout_valid;
        last_d  = cw_last;
        if (ena) begin
            unique case (state)
                IDLE: begin
                    sout_d  = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                MSG: begin
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    msg_d   = msg_q << 1;
                    cnt_d   = cnt + 2'd1;
                    if (cnt == 2'(K_LEN - 1)) begin
                        sout_d  = r[1];
                        state_d = PAR;
                        cnt_d   = 2'd0;
                    end else begin
                        sout_d = msg_q[K_LEN-2];
                    end
                end
                PAR: begin
                    valid_d = 1'b1;
                    sout_d  = r[1];
                    cnt_d   = cnt + 2'd1;
                    last_d  = (cnt == 2'(R_LEN - 2));
                    if (cnt == 2'(R_LEN - 1)) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                        sout_d  = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
            if (accept) begin
                state_d = MSG;
                cnt_d   = 2'd0;
                msg_d   = msg;
                sout_d  = msg[K_LEN-1];
                valid_d = 1'b1;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            msg_q      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            cw_last    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            msg_q      <= msg_d;
            sout       <= sout_d;
            sout_valid <= valid_d;
            cw_last    <= last_d;
        end
    end

`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
    // Collects c6..c1 as emitted; c0 is appended on the final emit.
    logic [N_LEN-2:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            cw_out   <= '0;
            cw_valid <= 1'b0;
        end else if (ena) begin
            if (valid_d) begin
                shadow <= {shadow[N_LEN-3:0], sout_d};
            end
            cw_valid <= last_d;
            if (last_d) begin
                cw_out <= {shadow, sout_d};
            end
        end
    end
`endif

endmodule

// File: tb/tb_cyclic_encoder.sv
// Randomized self-checking bench for cyclic_encoder against a polynomial-division model.
module tb_cyclic_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [3:0] msg = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       sout;
    logic       sout_valid;
    logic       cw_last;
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
    logic [6:0] cw_out;
    logic       cw_valid;
`endif

    int tests = 0;
    int fails = 0;

    cyclic_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .msg        (msg),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .cw_last    (cw_last)
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
        ,
        .cw_out     (cw_out),
        .cw_valid   (cw_valid)
`endif
    );

    always #5 clk = ~clk;

    // Codeword = m*x^3 + (m*x^3 mod g) by long division over GF(2).
    function automatic logic [6:0] ref_cw(input logic [3:0] m);
        logic [6:0] rem;
        logic [6:0] g;
        rem = {m, 3'b000};
        for (int d = 6; d >= 3; d--) begin
            if (rem[d]) begin
                g = 7'b0001011 << (d - 3);
                rem = rem ^ g;
            end
        end
        return {m, rem[2:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ena = 1'b1;
        in_valid = 1'b1;
        msg = 4'hF;
        tick;
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        tests++;
        if ({sout_valid, sout, cw_last} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outs got %b want 000", {sout_valid, sout, cw_last});
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
        ena = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_ena0 got %b want 0", in_ready);
        end
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
        tests++;
        if ({cw_valid, cw_out} !== 8'h00) begin
            fails++;
            $display("FAIL reset_par got %b want 0", {cw_valid, cw_out});
        end
`endif
        ena = 1'b1;
        tick;
        tests++;
        if ({sout_valid, sout, cw_last} !== 3'b000) begin
            fails++;
            $display("FAIL idle_outs got %b want 000", {sout_valid, sout, cw_last});
        end
    endtask

    task automatic test_vectors;
        logic [3:0] m;
        logic [6:0] e;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0: m = 4'b0001;
                1: m = 4'b1000;
                2: m = 4'b1111;
                3: m = 4'b0000;
                default: m = 4'($urandom_range(0, 15));
            endcase
            e = ref_cw(m);
            msg = m;
            in_valid = 1'b1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL vec_ready msg=%b got %b want 1", m, in_ready);
            end
            tick;
            in_valid = 1'b0;
            msg = 4'($urandom_range(0, 15));
            for (int j = 0; j < 7; j++) begin
                tests++;
                if ({sout_valid, sout, cw_last} !== {1'b1, e[6-j], j == 6}) begin
                    fails++;
                    $display("FAIL vec_bit msg=%b j=%0d got %b want %b", m, j,
                             {sout_valid, sout, cw_last}, {1'b1, e[6-j], j == 6});
                end
                tests++;
                if (in_ready !== (j == 6)) begin
                    fails++;
                    $display("FAIL vec_inready msg=%b j=%0d got %b", m, j, in_ready);
                end
`ifdef CYCLIC_ENC_PARALLEL_OUT_EN
                if (j == 6) begin
                    tests++;
                    if ({cw_valid, cw_out} !== {1'b1, e}) begin
                        fails++;
                        $display("FAIL vec_par msg=%b got %b want %b", m,
                                 {cw_valid, cw_out}, {1'b1, e});
                    end
                end
`endif
                tick;
            end
            tests++;
            if ({sout_valid, sout, cw_last} !== 3'b000) begin
                fails++;
                $display("FAIL vec_idle msg=%b got %b want 000", m,
                         {sout_valid, sout, cw_last});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a, b;
        logic [6:0] ea, eb;
        logic       eb_bit;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                a = 4'b0001;
                b = 4'b1000;
            end else begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
            end
            ea = ref_cw(a);
            eb = ref_cw(b);
            msg = a;
            in_valid = 1'b1;
            tick;
            msg = b;
            for (int j = 0; j < 14; j++) begin
                eb_bit = (j < 7) ? ea[6-j] : eb[13-j];
                tests++;
                if ({sout_valid, sout, cw_last} !== {1'b1, eb_bit, (j == 6 || j == 13)}) begin
                    fails++;
                    $display("FAIL b2b_bit a=%b b=%b j=%0d got %b want %b", a, b, j,
                             {sout_valid, sout, cw_last},
                             {1'b1, eb_bit, (j == 6 || j == 13)});
                end
                tests++;
                if (in_ready !== (j == 6 || j == 13)) begin
                    fails++;
                    $display("FAIL b2b_ready j=%0d got %b", j, in_ready);
                end
                tick;
                if (j == 6) in_valid = 1'b0;
            end
            tests++;
            if (sout_valid !== 1'b0) begin
                fails++;
                $display("FAIL b2b_end got %b want 0", sout_valid);
            end
        end
    endtask

    task automatic test_ena_stall;
        logic [6:0] e;
        e = ref_cw(4'b1000);
        msg = 4'b1000;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tests++;
            if ({sout_valid, sout, cw_last} !== {1'b1, e[6-j], j == 6}) begin
                fails++;
                $display("FAIL stall_bit j=%0d got %b want %b", j,
                         {sout_valid, sout, cw_last}, {1'b1, e[6-j], j == 6});
            end
            if (j == 1) begin
                ena = 1'b0;
                in_valid = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    tests++;
                    if (in_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_ready s=%0d got %b want 0", s, in_ready);
                    end
                    tick;
                    tests++;
                    if ({sout_valid, sout, cw_last} !== {1'b1, e[5], 1'b0}) begin
                        fails++;
                        $display("FAIL stall_hold s=%0d got %b want %b", s,
                                 {sout_valid, sout, cw_last}, {1'b1, e[5], 1'b0});
                    end
                end
                in_valid = 1'b0;
                ena = 1'b1;
            end
            tick;
        end
    endtask

    task automatic test_reset_abort;
        logic [6:0] e;
        msg = 4'b1111;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++;
        if ({sout_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL abort_state got %b want 01", {sout_valid, in_ready});
        end
        e = ref_cw(4'b0001);
        msg = 4'b0001;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            tests++;
            if ({sout_valid, sout, cw_last} !== {1'b1, e[6-j], j == 6}) begin
                fails++;
                $display("FAIL abort_bit j=%0d got %b want %b", j,
                         {sout_valid, sout, cw_last}, {1'b1, e[6-j], j == 6});
            end
            tick;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_ena_stall();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cyclic_encoder.md
CYCLIC_ENCODER -- requirements
Module: cyclic_encoder

Interface
REQ-001 The block SHALL have no parameters; code is fixed (7,4), generator g(x)=x^3+x+1, taken from cyclic_pkg.
REQ-002 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port: clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port: ena  input  1  advance enable; low freezes all state.
REQ-006 The block SHALL have port: msg  input  4  message {m3,m2,m1,m0}, m3 = highest degree.
REQ-007 The block SHALL have port: in_valid  input  1  msg valid.
REQ-008 The block SHALL have port: in_ready  output  1  encoder can accept msg this cycle.
REQ-009 The block SHALL have port: sout  output  1  serial codeword bit.
REQ-010 The block SHALL have port: sout_valid  output  1  sout carries a codeword bit.
REQ-011 The block SHALL have port: cw_last  output  1  high with the final (c0) bit.

Function
REQ-012 The block SHALL produce systematic codewords: c(x)=m(x)·x^3 + (m(x)·x^3 mod g(x)).
REQ-013 The block SHALL emit bits in order c6,c5,c4,c3 = m3,m2,m1,m0, then parity c2,c1,c0, one bit per ena cycle.
REQ-014 The block SHALL compute parity with a 3-stage LFSR r2:r0: f=bit^r2; r0<=f; r1<=r0^f; r2<=r1.
REQ-015 The block SHALL, in parity phase, shift the LFSR with zero feedback (r2<=r1, r1<=r0, r0<=0) and output r2.
REQ-016 The block SHALL use states IDLE, MSG (4 bits), PAR (3 bits), with a 2-bit bit counter.
REQ-017 Transitions SHALL be: IDLE->MSG on accept; MSG->PAR after 4th bit; PAR->IDLE after 3rd bit, or PAR->MSG on a same-cycle accept.
REQ-018 in_ready SHALL be (state==IDLE && ena) || (state==PAR && last parity bit && ena).
REQ-019 Accept SHALL be in_valid && in_ready; msg is captured and the LFSR is cleared on accept.
REQ-020 Latency SHALL be one cycle: sout/sout_valid are registered; c6 appears the cycle after accept.
REQ-021 Back-to-back accepts SHALL yield continuous sout_valid with no gap between codewords.
REQ-022 When ena is low, state, sout, sout_valid and cw_last SHALL hold, and in_ready SHALL be 0.
REQ-023 In IDLE with no accept, sout_valid and cw_last SHALL be 0 and sout SHALL be 0.
REQ-024 in_valid while in_ready is low SHALL be ignored (no capture).

Reset
REQ-025 On rst, the block SHALL enter IDLE, clear the LFSR, msg register and counter, and drive sout=0, sout_valid=0, cw_last=0.
REQ-026 rst SHALL override ena and in_valid; a codeword in progress is aborted with no further bits emitted.
REQ-027 in_ready SHALL equal ena in the first cycle after reset.

Configuration
REQ-028 With CYCLIC_ENC_PARALLEL_OUT_EN defined, the block SHALL add ports cw_out (output 7, {c6..c0}) and cw_valid (output 1).
REQ-029 With the macro defined, cw_valid SHALL pulse one cycle concurrent with cw_last, and cw_out SHALL hold the full codeword until the next cw_valid; both reset to 0.
REQ-030 Without the macro, those ports and their logic SHALL be absent; serial behaviour is identical.

Structure
REQ-031 cyclic_pkg SHALL hold N_LEN=7, K_LEN=4, R_LEN=3, GEN_POLY=4'b1011, and the state enum type.
REQ-032 The LFSR SHALL be a sub-module cyclic_lfsr3 (clk, rst, ena, clr, feedback_en, din, r[2:0]).

Verification
REQ-033 msg=4'b0001 accepted, ena=1 -> sout sequence 0,0,0,1,0,1,1; cw_last on 7th bit.
REQ-034 msg=4'b1000 -> 1,0,0,0,1,0,1; msg=4'b1111 -> 1111111; msg=4'b0000 -> 0000000.
REQ-035 Two msgs 0001 then 1000 with in_valid held -> 14 consecutive valid bits 0001011 1000101, in_ready high only on the IDLE and last-parity cycles.
REQ-036 ena low for 3 cycles after 2nd bit of 1000 -> outputs hold, in_ready=0; resumes to give 1000101.
REQ-037 rst asserted at 5th bit of 1111 -> next cycle sout_valid=0, in_ready=1; new msg 0001 encodes to 0001011.
REQ-038 With CYCLIC_ENC_PARALLEL_OUT_EN: msg 1000 -> cw_valid pulse with cw_out=7'b1000101 on cw_last cycle.
